// File: rtl/aes_key_schedule_pkg.sv
// Shared AES key-expansion definitions: S-box and Rcon tables, key-size
// derivations, schedule word type and engine FSM states.
package aes_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused; schedule indices run 1..10.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return (idx < 4'd11) ? RCON[idx] : 8'h00;
    endfunction

    function automatic int unsigned nk(input int unsigned key_len);
        return key_len / 32;
    endfunction

    function automatic int unsigned nr(input int unsigned key_len);
        return nk(key_len) + 6;
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-offer, round-key stream and round-key store read port of the key schedule.
interface aes_key_schedule_if #(
    parameter int unsigned KEY_LEN = 128
) ();
    logic               valid_in;
    logic               ready_out;
    logic [KEY_LEN-1:0] data_in;
    logic               valid_out;
    logic               ready_in;
    logic [127:0]       data_out;
    logic [3:0]         round_out;
    logic               last_out;
    logic [3:0]         rd_idx;
    logic [127:0]       rd_data;

    modport master (
        output valid_in, data_in, ready_in, rd_idx,
        input  ready_out, valid_out, data_out, round_out, last_out, rd_data
    );

    modport slave (
        input  valid_in, data_in, ready_in, rd_idx,
        output ready_out, valid_out, data_out, round_out, last_out, rd_data
    );
endinterface

// File: rtl/aes_key_schedule_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din_i,
    output logic [7:0] dout_c
);
    assign dout_c = sbox(din_i);
endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES key expansion: one schedule word per cycle, round keys streamed
// with valid/ready. Define AES_KEY_STORE_EN to add a readable round-key store.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned KEY_LEN  = 128,
    parameter int unsigned WORD_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_key_schedule_if.slave    bus
);

    localparam int unsigned NK    = nk(KEY_LEN);
    localparam int unsigned NR    = nr(KEY_LEN);
    localparam int unsigned TOTAL = 4 * (NR + 1);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned MOD_W = 3;

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_key_schedule: KEY_LEN must be 128, 192 or 256");
    end
    if (WORD_LEN != 32) begin : g_bad_word_len
        $error("aes_key_schedule: WORD_LEN must be 32");
    end

    state_e             state_q, state_d;
    word_t              win_q [NK];
    word_t              win_d [NK];
    word_t              asm_q [3];
    word_t              asm_d [3];
    logic [CNT_W-1:0]   i_q, i_d;
    logic [MOD_W-1:0]   j_q, j_d;
    logic [3:0]         rc_q, rc_d;
    logic [127:0]       dout_q, dout_d;
    logic               vout_q, vout_d;
    logic [3:0]         round_q, round_d;
    logic               last_q, last_d;
    logic               rdy_q, rdy_d;

    logic  hs, out_free, produce, key_phase;
    word_t prev_w, sub_in, sub_out, temp_w, new_w;

    assign hs        = vout_q && bus.ready_in;
    assign out_free  = !vout_q || bus.ready_in;
    assign key_phase = i_q < CNT_W'(NK);
    // The word closing a round needs the output register; the others go to the assembler.
    assign produce   = (state_q == ST_RUN) && (i_q < CNT_W'(TOTAL)) &&
                       ((i_q[1:0] != 2'd3) || out_free);

    // Single SubWord path, shared by the RotWord and the 256-bit mid-key transforms.
    assign prev_w = win_q[NK-1];
    assign sub_in = (j_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .din_i  (sub_in[8*b +: 8]),
            .dout_c (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (j_q == '0) begin
            temp_w = sub_out ^ {rcon(rc_q), 24'h0};
        end else if (NK == 8 && j_q == MOD_W'(4)) begin
            temp_w = sub_out;
        end
        new_w = key_phase ? win_q[0] : (win_q[0] ^ temp_w);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        asm_d   = asm_q;
        i_d     = i_q;
        j_d     = j_q;
        rc_d    = rc_q;
        dout_d  = dout_q;
        vout_d  = vout_q;
        round_d = round_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    state_d = ST_RUN;
                    for (int k = 0; k < int'(NK); k++) begin
                        win_d[k] = bus.data_in[KEY_LEN-1-32*k -: 32];
                    end
                    i_d  = '0;
                    j_d  = '0;
                    rc_d = 4'd1;
                end
            end
            ST_RUN: begin
                if (hs && last_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (hs) begin
            vout_d = 1'b0;
        end

        // Key words are recirculated through the window so it ends up holding w[i-NK..i-1].
        if (produce) begin
            for (int k = 0; k < int'(NK) - 1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[NK-1] = new_w;
            i_d = i_q + CNT_W'(1);
            j_d = (j_q == MOD_W'(NK - 1)) ? '0 : j_q + MOD_W'(1);
            if (!key_phase && j_q == '0) begin
                rc_d = rc_q + 4'd1;
            end
            case (i_q[1:0])
                2'd0: asm_d[0] = new_w;
                2'd1: asm_d[1] = new_w;
                2'd2: asm_d[2] = new_w;
                default: begin
                    dout_d  = {asm_q[0], asm_q[1], asm_q[2], new_w};
                    vout_d  = 1'b1;
                    round_d = i_q[5:2];
                    last_d  = (i_q[5:2] == 4'(NR));
                end
            endcase
        end

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < int'(NK); k++) begin
                win_q[k] <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                asm_q[k] <= '0;
            end
            i_q     <= '0;
            j_q     <= '0;
            rc_q    <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            round_q <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            asm_q   <= asm_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rc_q    <= rc_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            round_q <= round_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.ready_out = rdy_q;
    assign bus.valid_out = vout_q;
    assign bus.data_out  = dout_q;
    assign bus.round_out = round_q;
    assign bus.last_out  = last_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [NR+1];

    // Captures every delivered round key; a new accept starts from an empty store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= int'(NR); k++) begin
                store_q[k] <= '0;
            end
        end else if (state_q == ST_IDLE && bus.valid_in) begin
            for (int k = 0; k <= int'(NR); k++) begin
                store_q[k] <= '0;
            end
        end else if (hs) begin
            store_q[round_q] <= dout_q;
        end
    end

    assign bus.rd_data = (bus.rd_idx <= 4'(NR)) ? store_q[bus.rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^bus.rd_idx;
    assign bus.rd_data   = '0;
`endif

endmodule
